parity_share_ctrl: RTL and testbench



---
 rtl/parity_share_ctrl.sv | 136 +++++++++++++
 tb/tb_parity_share_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_share_ctrl.sv
// Round-robin shared serial parity engine: N_REQ requesters feed one bit-serial
// XOR folder; each result is tagged with the word and the source index.
module parity_share_ctrl #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int ODD    = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_parity,
  output logic [DATA_W-1:0]         out_data,
  output logic [$clog2(N_REQ)-1:0]  out_id,
  output logic                      busy
);

  localparam int   ID_W    = $clog2(N_REQ);
  localparam int   CNT_W   = $clog2(DATA_W);
  localparam logic ODD_BIT = (ODD != 0);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] words [N_REQ];
  logic [DATA_W-1:0] sh;
  logic              acc;
  logic [CNT_W-1:0]  cnt;
  logic [ID_W-1:0]   last;
  logic [ID_W-1:0]   gnt_idx;
  logic              gnt_any;
  logic              accept;
  logic              last_bit;
  int unsigned       scan;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign words[i] = req_data[i*DATA_W +: DATA_W];
  end

  assign last_bit = (cnt == CNT_W'(DATA_W - 1));
  assign busy     = (state != IDLE);

  // Scan upward from the slot after the last winner; first hit wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    scan    = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      scan = (32'(last) + k) % N_REQ;
      if (!gnt_any && req_valid[ID_W'(scan)]) begin
        gnt_any = 1'b1;
        gnt_idx = ID_W'(scan);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_any) begin
          req_ready[gnt_idx] = 1'b1;
          accept             = 1'b1;
          state_nx           = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) state_nx = DONE;
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh         <= '0;
      acc        <= 1'b0;
      cnt        <= '0;
      last       <= ID_W'(N_REQ - 1);
      out_valid  <= 1'b0;
      out_parity <= 1'b0;
      out_data   <= '0;
      out_id     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sh       <= words[gnt_idx];
            out_data <= words[gnt_idx];
            out_id   <= gnt_idx;
            acc      <= 1'b0;
            cnt      <= '0;
            last     <= gnt_idx;
          end
        end
        SHIFT: begin
          acc <= acc ^ sh[0];
          sh  <= sh >> 1;
          cnt <= cnt + 1'b1;
          // Fold in the final bit directly so the result lands on the DATA_W-th edge.
          if (last_bit) begin
            out_parity <= acc ^ sh[0] ^ ODD_BIT;
            out_valid  <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert ($onehot0(req_ready));
  end

endmodule

// File: tb/tb_parity_share_ctrl.sv
// Scoreboard bench for parity_share_ctrl: even- and odd-parity instances share
// stimulus; a round-robin reference model predicts grants, timing and results.
module tb_parity_share_ctrl;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic           out_ready;
  logic [N-1:0]   rdy_e, rdy_o;
  logic           ov_e, ov_o, par_e, par_o, busy_e, busy_o;
  logic [W-1:0]   dat_e, dat_o;
  logic [IW-1:0]  id_e, id_o;

  always #5 clk = ~clk;

  parity_share_ctrl #(.N_REQ(N), .DATA_W(W), .ODD(0)) u_even (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rdy_e), .out_valid(ov_e), .out_ready(out_ready),
    .out_parity(par_e), .out_data(dat_e), .out_id(id_e), .busy(busy_e)
  );

  parity_share_ctrl #(.N_REQ(N), .DATA_W(W), .ODD(1)) u_odd (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rdy_o), .out_valid(ov_o), .out_ready(out_ready),
    .out_parity(par_o), .out_data(dat_o), .out_id(id_o), .busy(busy_o)
  );

  typedef struct {
    logic [W-1:0] data;
    int           id;
    logic         pe;
    logic         po;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit           pend [N];
  logic [W-1:0] pdat [N];
  int           m_last;
  bit           m_job;
  int           m_vcyc;
  int           t;
  bit           rand_en;
  bit           refill;
  int           or_mode;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", name, got, exp, t);
    end
  endtask

  function automatic int rr_pick(input int lst, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++)
      if (v[(lst + k) % N]) return (lst + k) % N;
    return -1;
  endfunction

  // One clock: drive inputs, check at negedge, advance the model at posedge.
  task automatic step();
    int          g;
    bit          ov_exp;
    bit          hs;
    bit          rst_s;
    logic [31:0] rdy_exp;
    if (rand_en)
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          pdat[i] = W'($urandom);
        end
    case (or_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = pend[i];
      req_data[i*W +: W]   = pdat[i];
    end
    @(negedge clk);
    rst_s   = rst;
    g       = m_job ? -1 : rr_pick(m_last, req_valid);
    ov_exp  = m_job && (t >= m_vcyc);
    hs      = ov_exp && out_ready;
    rdy_exp = (g < 0) ? 32'd0 : (32'd1 << g);
    chk("req_ready_even", rdy_e, rdy_exp);
    chk("req_ready_odd", rdy_o, rdy_exp);
    chk("out_valid_even", ov_e, ov_exp);
    chk("out_valid_odd", ov_o, ov_exp);
    chk("busy_even", busy_e, m_job);
    chk("busy_odd", busy_o, m_job);
    @(posedge clk);
    t++;
    if (rst_s) begin
      m_job  = 1'b0;
      m_last = N - 1;
      sb.delete();
    end else begin
      if (hs) m_job = 1'b0;
      if (g >= 0) begin
        sb.push_back('{data: pdat[g], id: g, pe: ^pdat[g], po: ~^pdat[g]});
        m_job  = 1'b1;
        m_vcyc = t + W;
        m_last = g;
        pend[g] = 1'b0;
        if (refill) begin
          pend[g] = 1'b1;
          pdat[g] = W'($urandom);
        end
      end
    end
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Monitor: pops the scoreboard on each output handshake, checks hold-stability.
  initial begin : monitor
    logic          pv;
    logic          phs;
    logic [W-1:0]  pd;
    logic [IW-1:0] pi;
    logic          pp;
    exp_t          e;
    pv  = 1'b0;
    phs = 1'b0;
    pd  = '0;
    pi  = '0;
    pp  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        pv = 1'b0;
        continue;
      end
      if (pv && !phs && ov_e) begin
        chk("hold_data", dat_e, pd);
        chk("hold_id", id_e, pi);
        chk("hold_parity", par_e, pp);
      end
      if (ov_e && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got id %0d data %0h, required none", id_e, dat_e);
        end else begin
          e = sb.pop_front();
          chk("out_data_even", dat_e, e.data);
          chk("out_id_even", id_e, e.id);
          chk("out_parity_even", par_e, e.pe);
          chk("out_data_odd", dat_o, e.data);
          chk("out_id_odd", id_o, e.id);
          chk("out_parity_odd", par_o, e.po);
        end
      end
      pv  = ov_e;
      phs = ov_e && out_ready;
      pd  = dat_e;
      pi  = id_e;
      pp  = par_e;
    end
  end

  initial begin : stim
    logic [W-1:0] bw [3];
    rst       = 1'b1;
    out_ready = 1'b0;
    req_valid = '0;
    req_data  = '0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      pdat[i] = '0;
    end
    m_last  = N - 1;
    m_job   = 1'b0;
    m_vcyc  = 0;
    t       = 0;
    rand_en = 1'b0;
    refill  = 1'b0;
    or_mode = 1;

    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", ov_e, 0);
    chk("rst_out_parity", par_e, 0);
    chk("rst_out_data", dat_e, 0);
    chk("rst_out_id", id_e, 0);
    chk("rst_busy", busy_e, 0);
    chk("rst_req_ready", rdy_e, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single request, known word
    pend[0] = 1'b1;
    pdat[0] = 8'hB5;
    run(14);

    // Boundary words
    bw[0] = 8'h00;
    bw[1] = 8'hFF;
    bw[2] = 8'h01;
    for (int i = 0; i < 3; i++) begin
      pend[2] = 1'b1;
      pdat[2] = bw[i];
      run(12);
    end

    // Reset so requester 0 leads, then all four continuously valid
    rst = 1'b1;
    step();
    rst = 1'b0;
    refill = 1'b1;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b1;
      pdat[i] = W'($urandom);
    end
    run(60);
    refill = 1'b0;
    run(45);

    // Backpressure held in DONE, with a competitor waiting
    or_mode = 0;
    pend[1] = 1'b1;
    pdat[1] = W'($urandom);
    pend[3] = 1'b1;
    pdat[3] = W'($urandom);
    run(W + 7);
    or_mode = 1;
    run(25);

    // Fairness: serve 1, then 0 and 3 compete
    pend[1] = 1'b1;
    pdat[1] = W'($urandom);
    run(12);
    pend[0] = 1'b1;
    pdat[0] = W'($urandom);
    pend[3] = 1'b1;
    pdat[3] = W'($urandom);
    run(25);

    // Reset in the middle of shifting
    pend[2] = 1'b1;
    pdat[2] = W'($urandom);
    run(4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(3);
    pend[2] = 1'b1;
    pdat[2] = W'($urandom);
    pend[1] = 1'b1;
    pdat[1] = W'($urandom);
    run(25);

    // Random traffic with random backpressure
    rand_en = 1'b1;
    or_mode = 2;
    run(400);
    rand_en = 1'b0;
    or_mode = 1;
    run(80);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
